lut_ram_wr_arbiter: RTL and testbench
=====================================

Name: lut_ram_wr_arbiter

Overview:
- Shares the single synchronous write port of a distributed LUT RAM between NUM_PORTS independent write requesters.
- Uses round-robin arbitration with valid/ready handshakes.
- Optionally clears the whole RAM (zero-fill sweep) after reset or on request.
- Sits between application datapath writers and the LUT RAM; RAM read ports are untouched and stay asynchronous.

Parameters:
NUM_PORTS, 4, number of write requesters (>=2)
DATA_WIDTH, 256, RAM word width
ADDR_WIDTH, 6, RAM address width; depth = 2**ADDR_WIDTH (keep <=10 for distributed RAM)
INIT_ON_RESET, 1, 1 = zero-fill sweep after reset; 0 = enter RUN directly

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
s_wr_addr  in  NUM_PORTS*ADDR_WIDTH  per-port write address, port i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
s_wr_data  in  NUM_PORTS*DATA_WIDTH  per-port write data, same slicing
s_wr_valid  in  NUM_PORTS  per-port write request
s_wr_ready  out  NUM_PORTS  per-port accept; handshake = valid & ready
clear_req  in  1  single-cycle pulse: re-run zero-fill sweep
ram_write_addr  out  ADDR_WIDTH  to RAM write_addr
ram_data_in  out  DATA_WIDTH  to RAM data_in
ram_wr_en  out  1  to RAM wr_en
grant_idx  out  $clog2(NUM_PORTS)  index of port that produced current ram_wr_en (debug)
init_done  out  1  high when in RUN state

Behaviour:
- States: INIT (zero-fill sweep), RUN.
- Reset values: ram_wr_en=0, ram_write_addr=0, ram_data_in=0, grant_idx=0, init_done=0, s_wr_ready=0, sweep counter=0, rr pointer=0.
- State after reset: INIT if INIT_ON_RESET=1, else RUN with init_done=1 in the first post-reset cycle.
- INIT:
  - Each cycle drives ram_wr_en=1, ram_data_in=0, ram_write_addr=counter; counter increments.
  - s_wr_ready is all 0.
  - Sweep takes exactly 2**ADDR_WIDTH cycles.
  - After the write to address 2**ADDR_WIDTH-1, the next state is RUN and init_done=1 in that cycle.
  - clear_req is ignored in INIT.
- RUN arbitration:
  - Combinational round-robin over s_wr_valid.
  - Search starts at port (rr_ptr+1) mod NUM_PORTS.
  - Exactly one s_wr_ready bit is high: the winner, and only if any valid is set. ready depends on valid.
- RUN handshake:
  - Winner's addr/data are registered into ram_write_addr/ram_data_in, with ram_wr_en=1 on the next cycle. Latency is 1 cycle.
  - rr_ptr becomes the winner index.
  - grant_idx is updated with the output registers.
- Throughput: one write per cycle, back-to-back. A single persistent requester is granted every cycle.
- No handshake in a cycle: ram_wr_en=0 the next cycle; addr/data outputs hold their previous values.
- clear_req in RUN:
  - No ready is asserted that cycle.
  - The next cycle enters INIT with counter=0.
  - A write registered in the previous cycle still completes, because its ram_wr_en is already on the outputs.
- Same-address writes: all are accepted in grant order; the last accepted wins.
- Reset mid-sweep or mid-traffic: immediate return to reset values; the sweep restarts from address 0.
- Requesters must hold valid/addr/data stable until ready; the block does not check this.

Decomposition:
- Package lut_ram_arb_pkg holds:
  - typedef enum logic {ST_INIT, ST_RUN} lut_ram_arb_state_t
  - a localparam helper for grant index width
- Sub-module rr_arbiter (NUM_PORTS) holds:
  - Inputs: req, ptr. Outputs: one-hot grant, grant index.
  - Purely combinational, reusable elsewhere.
- Top level holds the FSM, sweep counter and output registers.

Test Plan:
- Reset with INIT_ON_RESET=1, ADDR_WIDTH=4 -> 16 consecutive cycles of ram_wr_en=1, addr 0..15, data 0; init_done=1 on cycle 17; s_wr_ready=0 throughout the sweep.
- RUN, all 4 valid continuously with distinct addr 1..4 -> grants in order 1,2,3,0,1... (rr_ptr=0 after reset); ram_wr_en=1 every cycle; ram_write_addr follows the grant one cycle later.
- Only port 2 valid for 5 cycles, addr 3..7 -> s_wr_ready=4'b0100 every cycle; five back-to-back RAM writes, grant_idx=2.
- Port 0 valid at the same cycle as a clear_req pulse -> s_wr_ready=0 that cycle; a full 16-cycle sweep follows; port 0 is accepted on the first RUN cycle after the sweep.
- rst asserted at sweep address 9 -> outputs return to 0; the sweep restarts at address 0 and completes after 16 cycles.
- Ports 1 and 3 both write addr 5 with data 0xA/0xB in consecutive grants -> RAM word 5 reads 0xB afterwards (checked via a behavioural RAM model).

Source files
------------

// File: rtl/lut_ram_arb_pkg.sv
// Shared types and helpers for the LUT RAM write-port arbiter.
// Holds the controller state encoding and the grant index width helper.
package lut_ram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } lut_ram_arb_state_t;

    localparam int MIN_PORTS = 2;

    // Width of a port index; never collapses to zero bits
    function automatic int grant_idx_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/lut_ram_wr_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and wraps.
// Produces a one-hot grant and its index; grant is all zero when req is empty.
module rr_arbiter
    import lut_ram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = grant_idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);

    logic found_s;
    int   cand_s;

    // Scan ports in rotating priority order and keep the first requester
    always_comb begin
        grant     = {NUM_PORTS{1'b0}};
        grant_idx = {IDX_W{1'b0}};
        found_s   = 1'b0;
        cand_s    = 0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand_s = (int'(ptr) + off) % NUM_PORTS;
            if (!found_s && req[cand_s]) begin
                found_s       = 1'b1;
                grant[cand_s] = 1'b1;
                grant_idx     = IDX_W'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/lut_ram_wr_arbiter.sv
// Shares one synchronous LUT RAM write port between NUM_PORTS requesters,
// with an optional zero-fill sweep after reset or on clear_req.
module lut_ram_wr_arbiter
    import lut_ram_arb_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int DATA_WIDTH    = 256,
    parameter int ADDR_WIDTH    = 6,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      s_wr_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      s_wr_data,
    input  logic [NUM_PORTS-1:0]                 s_wr_valid,
    output logic [NUM_PORTS-1:0]                 s_wr_ready,
    input  logic                                 clear_req,
    output logic [ADDR_WIDTH-1:0]                ram_write_addr,
    output logic [DATA_WIDTH-1:0]                ram_data_in,
    output logic                                 ram_wr_en,
    output logic [grant_idx_width(NUM_PORTS)-1:0] grant_idx,
    output logic                                 init_done
);

    localparam int IDX_W = grant_idx_width(NUM_PORTS);

    lut_ram_arb_state_t     state_r;
    // Extra MSB marks that the last address has been written
    logic [ADDR_WIDTH:0]    sweep_cnt_r;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [NUM_PORTS-1:0]   grant_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic [ADDR_WIDTH-1:0]  win_addr_s;
    logic [DATA_WIDTH-1:0]  win_data_s;
    logic                   hs_s;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_arbiter (
        .req       (s_wr_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (win_idx_s)
    );

    assign win_addr_s = s_wr_addr[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_data_s = s_wr_data[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
    assign hs_s       = |s_wr_ready;

    // Accept only in RUN, and never in the cycle a clear is requested
    always_comb begin
        if ((state_r == ST_RUN) && !clear_req) begin
            s_wr_ready = grant_s & s_wr_valid;
        end else begin
            s_wr_ready = {NUM_PORTS{1'b0}};
        end
    end

    // Controller FSM, sweep counter, round-robin pointer and RAM-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            sweep_cnt_r    <= {(ADDR_WIDTH+1){1'b0}};
            rr_ptr_r       <= {IDX_W{1'b0}};
            ram_wr_en      <= 1'b0;
            ram_write_addr <= {ADDR_WIDTH{1'b0}};
            ram_data_in    <= {DATA_WIDTH{1'b0}};
            grant_idx      <= {IDX_W{1'b0}};
            init_done      <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (sweep_cnt_r[ADDR_WIDTH]) begin
                        state_r     <= ST_RUN;
                        sweep_cnt_r <= {(ADDR_WIDTH+1){1'b0}};
                        ram_wr_en   <= 1'b0;
                        init_done   <= 1'b1;
                    end else begin
                        ram_wr_en      <= 1'b1;
                        ram_write_addr <= sweep_cnt_r[ADDR_WIDTH-1:0];
                        ram_data_in    <= {DATA_WIDTH{1'b0}};
                        sweep_cnt_r    <= sweep_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
                        init_done      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        state_r     <= ST_INIT;
                        sweep_cnt_r <= {(ADDR_WIDTH+1){1'b0}};
                        ram_wr_en   <= 1'b0;
                        init_done   <= 1'b0;
                    end else if (hs_s) begin
                        ram_wr_en      <= 1'b1;
                        ram_write_addr <= win_addr_s;
                        ram_data_in    <= win_data_s;
                        grant_idx      <= win_idx_s;
                        rr_ptr_r       <= win_idx_s;
                        init_done      <= 1'b1;
                    end else begin
                        ram_wr_en <= 1'b0;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_INIT;
                    sweep_cnt_r <= {(ADDR_WIDTH+1){1'b0}};
                    ram_wr_en   <= 1'b0;
                    init_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_ram_wr_arbiter.sv
// Self-checking bench for lut_ram_wr_arbiter: randomized requesters checked
// against a round-robin/RAM reference model held in the bench.
module tb_lut_ram_wr_arbiter;

    localparam int NP    = 4;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr_a [NP];
    logic [DW-1:0] data_a [NP];
    logic [NP*AW-1:0] s_wr_addr;
    logic [NP*DW-1:0] s_wr_data;
    logic [NP-1:0] s_wr_valid = '0;
    logic [NP-1:0] s_wr_ready;
    logic          clear_req = 1'b0;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_data_in;
    logic          ram_wr_en;
    logic [1:0]    grant_idx;
    logic          init_done;

    logic [DW-1:0] ram_m   [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];
    int cmp_cnt = 0;
    int err_cnt = 0;
    int ptr_m   = 0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;
    logic [1:0]    last_gi;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NP; g++) begin : g_pack
        assign s_wr_addr[g*AW +: AW] = addr_a[g];
        assign s_wr_data[g*DW +: DW] = data_a[g];
    end

    lut_ram_wr_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
        .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready), .clear_req(clear_req),
        .ram_write_addr(ram_write_addr), .ram_data_in(ram_data_in),
        .ram_wr_en(ram_wr_en), .grant_idx(grant_idx), .init_done(init_done)
    );

    // Behavioural LUT RAM driven by the arbiter's write port
    always @(posedge clk) begin
        if (ram_wr_en) ram_m[ram_write_addr] <= ram_data_in;
    end

    // Round-robin rule: first valid port after the last winner, wrapping
    function automatic int pick(input logic [NP-1:0] v, input int ptr);
        for (int off = 1; off <= NP; off++) begin
            if (v[(ptr + off) % NP]) return (ptr + off) % NP;
        end
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_wr_valid = '0; clear_req = 1'b0;
        repeat (3) cyc();
        cmp_cnt++;
        if ({ram_wr_en, ram_write_addr, ram_data_in, grant_idx, init_done, s_wr_ready} !== '0) begin
            err_cnt++;
            $display("FAIL reset_values: got en=%b addr=%0d data=%h gi=%0d done=%b rdy=%b, want all 0",
                     ram_wr_en, ram_write_addr, ram_data_in, grant_idx, init_done, s_wr_ready);
        end
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            s_wr_valid = (k == DEPTH-1) ? '0 : NP'($urandom);
            cyc();
            cmp_cnt++;
            if ({ram_wr_en, ram_write_addr, ram_data_in, init_done, s_wr_ready} !== {1'b1, AW'(k), DW'(0), 1'b0, NP'(0)}) begin
                err_cnt++;
                $display("FAIL reset_sweep[%0d]: got en=%b addr=%0d data=%h done=%b rdy=%b, want en=1 addr=%0d data=0 done=0 rdy=0",
                         k, ram_wr_en, ram_write_addr, ram_data_in, init_done, s_wr_ready, k);
            end
        end
        cyc();
        cmp_cnt++;
        if ({init_done, ram_wr_en} !== 2'b10) begin
            err_cnt++;
            $display("FAIL reset_sweep_done: got done=%b en=%b, want done=1 en=0", init_done, ram_wr_en);
        end
        cmp_cnt++;
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
        if (ram_m !== exp_mem) begin
            err_cnt++;
            $display("FAIL reset_ram_zero: RAM word 0=%h 15=%h, want 0", ram_m[0], ram_m[DEPTH-1]);
        end
        ptr_m = 0; last_addr = AW'(DEPTH-1); last_data = '0; last_gi = 2'd0;
    endtask

    task automatic test_all_valid();
        int w;
        for (int i = 0; i < NP; i++) begin
            addr_a[i] = AW'(i + 1);
            data_a[i] = $urandom;
        end
        s_wr_valid = '1;
        for (int n = 0; n < 8; n++) begin
            #1;
            w = pick(s_wr_valid, ptr_m);
            cmp_cnt++;
            if (s_wr_ready !== (NP'(1) << w)) begin
                err_cnt++;
                $display("FAIL all_valid_ready[%0d]: got %b, want port %0d", n, s_wr_ready, w);
            end
            cyc();
            cmp_cnt++;
            if ({ram_wr_en, ram_write_addr, ram_data_in, grant_idx} !== {1'b1, addr_a[w], data_a[w], 2'(w)}) begin
                err_cnt++;
                $display("FAIL all_valid_write[%0d]: got en=%b addr=%0d data=%h gi=%0d, want en=1 addr=%0d data=%h gi=%0d",
                         n, ram_wr_en, ram_write_addr, ram_data_in, grant_idx, addr_a[w], data_a[w], w);
            end
            exp_mem[addr_a[w]] = data_a[w];
            ptr_m = w; last_addr = addr_a[w]; last_data = data_a[w]; last_gi = 2'(w);
        end
        s_wr_valid = '0;
    endtask

    task automatic test_single_port();
        s_wr_valid = 4'b0100;
        for (int j = 0; j < 5; j++) begin
            addr_a[2] = AW'(3 + j);
            data_a[2] = $urandom;
            #1;
            cmp_cnt++;
            if (s_wr_ready !== 4'b0100) begin
                err_cnt++;
                $display("FAIL single_ready[%0d]: got %b, want 0100", j, s_wr_ready);
            end
            cyc();
            cmp_cnt++;
            if ({ram_wr_en, ram_write_addr, ram_data_in, grant_idx} !== {1'b1, AW'(3 + j), data_a[2], 2'd2}) begin
                err_cnt++;
                $display("FAIL single_write[%0d]: got en=%b addr=%0d data=%h gi=%0d, want en=1 addr=%0d data=%h gi=2",
                         j, ram_wr_en, ram_write_addr, ram_data_in, grant_idx, 3 + j, data_a[2]);
            end
            exp_mem[addr_a[2]] = data_a[2];
        end
        ptr_m = 2; last_addr = addr_a[2]; last_data = data_a[2]; last_gi = 2'd2;
        s_wr_valid = '0;
    endtask

    task automatic test_clear();
        addr_a[0] = AW'(9);
        data_a[0] = $urandom;
        s_wr_valid = 4'b0001;
        clear_req = 1'b1;
        #1;
        cmp_cnt++;
        if (s_wr_ready !== 4'b0000) begin
            err_cnt++;
            $display("FAIL clear_ready: got %b, want 0000", s_wr_ready);
        end
        cyc();
        clear_req = 1'b0;
        cmp_cnt++;
        if ({ram_wr_en, init_done, s_wr_ready} !== {1'b0, 1'b0, NP'(0)}) begin
            err_cnt++;
            $display("FAIL clear_enter: got en=%b done=%b rdy=%b, want 0 0 0000", ram_wr_en, init_done, s_wr_ready);
        end
        for (int k = 0; k < DEPTH; k++) begin
            cyc();
            cmp_cnt++;
            if ({ram_wr_en, ram_write_addr, ram_data_in, init_done, s_wr_ready} !== {1'b1, AW'(k), DW'(0), 1'b0, NP'(0)}) begin
                err_cnt++;
                $display("FAIL clear_sweep[%0d]: got en=%b addr=%0d data=%h done=%b rdy=%b, want en=1 addr=%0d data=0 done=0 rdy=0",
                         k, ram_wr_en, ram_write_addr, ram_data_in, init_done, s_wr_ready, k);
            end
        end
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
        cyc();
        cmp_cnt++;
        if ({init_done, ram_wr_en, s_wr_ready} !== {1'b1, 1'b0, NP'(1) << pick(4'b0001, ptr_m)}) begin
            err_cnt++;
            $display("FAIL clear_first_run: got done=%b en=%b rdy=%b, want done=1 en=0 rdy=0001", init_done, ram_wr_en, s_wr_ready);
        end
        cyc();
        cmp_cnt++;
        if ({ram_wr_en, ram_write_addr, ram_data_in, grant_idx} !== {1'b1, AW'(9), data_a[0], 2'd0}) begin
            err_cnt++;
            $display("FAIL clear_accept: got en=%b addr=%0d data=%h gi=%0d, want en=1 addr=9 data=%h gi=0",
                     ram_wr_en, ram_write_addr, ram_data_in, grant_idx, data_a[0]);
        end
        exp_mem[9] = data_a[0];
        ptr_m = 0; last_addr = AW'(9); last_data = data_a[0]; last_gi = 2'd0;
        s_wr_valid = '0;
    endtask

    task automatic test_rst_midsweep();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        cmp_cnt++;
        if ({ram_wr_en, ram_write_addr} !== {1'b1, AW'(9)}) begin
            err_cnt++;
            $display("FAIL midsweep_pos: got en=%b addr=%0d, want en=1 addr=9", ram_wr_en, ram_write_addr);
        end
        rst = 1'b1;
        cyc();
        cmp_cnt++;
        if ({ram_wr_en, ram_write_addr, ram_data_in, grant_idx, init_done} !== '0) begin
            err_cnt++;
            $display("FAIL midsweep_reset: got en=%b addr=%0d data=%h gi=%0d done=%b, want all 0",
                     ram_wr_en, ram_write_addr, ram_data_in, grant_idx, init_done);
        end
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            cyc();
            cmp_cnt++;
            if ({ram_wr_en, ram_write_addr, ram_data_in, init_done} !== {1'b1, AW'(k), DW'(0), 1'b0}) begin
                err_cnt++;
                $display("FAIL midsweep_restart[%0d]: got en=%b addr=%0d data=%h done=%b, want en=1 addr=%0d data=0 done=0",
                         k, ram_wr_en, ram_write_addr, ram_data_in, init_done, k);
            end
        end
        cyc();
        cmp_cnt++;
        if ({init_done, ram_wr_en} !== 2'b10) begin
            err_cnt++;
            $display("FAIL midsweep_done: got done=%b en=%b, want done=1 en=0", init_done, ram_wr_en);
        end
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
        ptr_m = 0; last_addr = AW'(DEPTH-1); last_data = '0; last_gi = 2'd0;
    endtask

    task automatic test_same_addr();
        addr_a[1] = AW'(5); data_a[1] = DW'(32'hA);
        addr_a[3] = AW'(5); data_a[3] = DW'(32'hB);
        s_wr_valid = 4'b1010;
        for (int n = 0; n < 2; n++) begin
            int w;
            #1;
            w = pick(s_wr_valid, ptr_m);
            cmp_cnt++;
            if ({s_wr_ready, ram_wr_en} !== {NP'(1) << w, (n == 1)}) begin
                err_cnt++;
                $display("FAIL same_addr_ready[%0d]: got rdy=%b en=%b, want port %0d", n, s_wr_ready, ram_wr_en, w);
            end
            cyc();
            cmp_cnt++;
            if ({ram_wr_en, ram_write_addr, ram_data_in, grant_idx} !== {1'b1, AW'(5), data_a[w], 2'(w)}) begin
                err_cnt++;
                $display("FAIL same_addr_write[%0d]: got en=%b addr=%0d data=%h gi=%0d, want en=1 addr=5 data=%h gi=%0d",
                         n, ram_wr_en, ram_write_addr, ram_data_in, grant_idx, data_a[w], w);
            end
            exp_mem[5] = data_a[w];
            s_wr_valid[w] = 1'b0;
            ptr_m = w; last_addr = AW'(5); last_data = data_a[w]; last_gi = 2'(w);
        end
        cyc();
        cmp_cnt++;
        if ({ram_wr_en, ram_write_addr, ram_data_in} !== {1'b0, last_addr, last_data}) begin
            err_cnt++;
            $display("FAIL same_addr_hold: got en=%b addr=%0d data=%h, want en=0 addr=%0d data=%h",
                     ram_wr_en, ram_write_addr, ram_data_in, last_addr, last_data);
        end
        cyc();
        cmp_cnt++;
        if (ram_m[5] !== DW'(32'hB)) begin
            err_cnt++;
            $display("FAIL same_addr_last_wins: RAM[5]=%h, want 0000000b", ram_m[5]);
        end
    endtask

    task automatic test_random();
        int w;
        logic [NP-1:0] exp_rdy;
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NP; i++) begin
                if (!s_wr_valid[i] && ($urandom_range(0, 2) == 0)) begin
                    s_wr_valid[i] = 1'b1;
                    addr_a[i] = AW'($urandom);
                    data_a[i] = $urandom;
                end
            end
            #1;
            w = pick(s_wr_valid, ptr_m);
            exp_rdy = (w >= 0) ? (NP'(1) << w) : NP'(0);
            cmp_cnt++;
            if (s_wr_ready !== exp_rdy) begin
                err_cnt++;
                $display("FAIL random_ready[%0d]: got %b, want %b", n, s_wr_ready, exp_rdy);
            end
            cyc();
            if (w >= 0) begin
                last_addr = addr_a[w]; last_data = data_a[w]; last_gi = 2'(w);
                exp_mem[addr_a[w]] = data_a[w];
                ptr_m = w;
                s_wr_valid[w] = 1'b0;
            end
            cmp_cnt++;
            if ({ram_wr_en, ram_write_addr, ram_data_in, grant_idx} !== {(w >= 0), last_addr, last_data, last_gi}) begin
                err_cnt++;
                $display("FAIL random_write[%0d]: got en=%b addr=%0d data=%h gi=%0d, want en=%b addr=%0d data=%h gi=%0d",
                         n, ram_wr_en, ram_write_addr, ram_data_in, grant_idx, (w >= 0), last_addr, last_data, last_gi);
            end
        end
        s_wr_valid = '0;
        cyc();
        cyc();
        cmp_cnt++;
        if (ram_m !== exp_mem) begin
            err_cnt++;
            for (int a = 0; a < DEPTH; a++) begin
                if (ram_m[a] !== exp_mem[a])
                    $display("FAIL random_ram[%0d]: got %h, want %h", a, ram_m[a], exp_mem[a]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            addr_a[i] = '0;
            data_a[i] = '0;
        end
        test_reset();
        test_all_valid();
        test_single_port();
        test_clear();
        test_rst_midsweep();
        test_same_addr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
